// File: rtl/divisor_pkg.sv
// Shared types and constants for the restoring divider.
package divisor_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITERS = DIV_WIDTH;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift dividend bit into the remainder,
// subtract the divisor when it fits and record the quotient bit.
module div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] den_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  logic [Width:0] rem_t;
  logic           fits;

  // One extra bit keeps the shifted remainder exact when the divisor uses the top bit.
  assign rem_t = {rem_i, quo_i[Width-1]};
  assign fits  = (rem_t >= {1'b0, den_i});
  assign rem_o = fits ? (rem_t[Width-1:0] - den_i) : rem_t[Width-1:0];
  assign quo_o = {quo_i[Width-2:0], fits};

endmodule

// File: rtl/divisor_restaurador.sv
// Multicycle signed restoring divider on the div_start/div_fim handshake.
// Define DIVISOR_DIVU_EN to add the div_unsigned input for divu operations.
module divisor_restaurador
  import divisor_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIVISOR_DIVU_EN
  input  logic             div_unsigned,
`endif
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_fim,
  output logic             div_zero,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  div_state_e       state_q;
  logic [WIDTH-1:0] den_q, rem_q, quo_q, lo_q, hi_q;
  logic [CntW-1:0]  cnt_q;
  logic             sgn_quo_q, sgn_rem_q;
  logic             fim_q, zero_q, busy_q;

  logic             op_signed;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             last_iter;

`ifdef DIVISOR_DIVU_EN
  assign op_signed = ~div_unsigned;
`else
  assign op_signed = 1'b1;
`endif

  assign neg_a     = op_signed & a[WIDTH-1];
  assign neg_b     = op_signed & b[WIDTH-1];
  assign abs_a     = neg_a ? (-a) : a;
  assign abs_b     = neg_b ? (-b) : b;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  div_step #(
    .Width(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .den_i(den_q),
    .rem_o(rem_step),
    .quo_o(quo_step)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      den_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      fim_q     <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_start) begin
            busy_q <= 1'b1;
            if (b == '0) begin
              // lo/hi are left untouched so the controller sees the previous result.
              state_q <= DONE;
              fim_q   <= 1'b1;
              zero_q  <= 1'b1;
            end else begin
              state_q   <= ITER;
              den_q     <= abs_b;
              quo_q     <= abs_a;
              rem_q     <= '0;
              cnt_q     <= '0;
              sgn_quo_q <= neg_a ^ neg_b;
              sgn_rem_q <= neg_a;
            end
          end
        end
        ITER: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= sgn_quo_q ? (-quo_q) : quo_q;
          hi_q    <= sgn_rem_q ? (-rem_q) : rem_q;
          fim_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          fim_q   <= 1'b0;
          zero_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign lo       = lo_q;
  assign hi       = hi_q;
  assign div_fim  = fim_q;
  assign div_zero = zero_q;
  assign busy     = busy_q;

endmodule
